// File: rtl/z_read_scheduler_pkg.sv
// z_read_scheduler_pkg: span field widths, span record and scheduler FSM encoding
package z_read_scheduler_pkg;

    localparam int ADDR_W = 29;
    localparam int PIX_W  = 64;
    localparam int MASK_W = 2;

    typedef enum logic [1:0] {
        ZRS_RUN    = 2'd0,
        ZRS_DRAIN  = 2'd1,
        ZRS_SWITCH = 2'd2
    } zrs_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] color_address;
        logic [PIX_W-1:0]  color;
        logic [ADDR_W-1:0] z_address;
        logic [PIX_W-1:0]  z;
        logic [MASK_W-1:0] pixel_active;
    } span_t;

endpackage

// File: rtl/z_read_scheduler.sv
// z_read_scheduler: one-slot span holder issuing Z reads and FIFO enqueues,
// with credit throttling and a drain-then-switch sequence on Z-mode changes.
module z_read_scheduler
    import z_read_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int SLACK           = 4,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       z_request,
    output logic                       z_active,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_color_address,
    input  logic [PIX_W-1:0]           in_color,
    input  logic [ADDR_W-1:0]          in_z_address,
    input  logic [PIX_W-1:0]           in_z,
    input  logic [MASK_W-1:0]          in_pixel_active,
    output logic [ADDR_W-1:0]          read_address,
    output logic                       read_read,
    input  logic                       read_waitrequest,
    input  logic [FIFO_DEPTH_LOG2-1:0] fifo_size,
    output logic                       enqueue,
    output logic [ADDR_W-1:0]          color_address,
    output logic [PIX_W-1:0]           color,
    output logic [ADDR_W-1:0]          z_address,
    output logic [PIX_W-1:0]           z,
    output logic [MASK_W-1:0]          pixel_active
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [FIFO_DEPTH_LOG2:0] CREDIT_LIMIT = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH - SLACK);

    zrs_state_e       state_q, state_d;
    span_t            slot_q, slot_d;
    logic             slot_valid_q, slot_valid_d;
    logic             z_active_q, z_active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fifo_empty, credit_ok, mode_match, slot_fire, accept;

    assign fifo_empty = fifo_size == '0;
    assign credit_ok  = {1'b0, fifo_size} < CREDIT_LIMIT;
    assign mode_match = z_request == z_active_q;
    assign slot_fire  = slot_valid_q && (!z_active_q || !read_waitrequest);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ZRS_RUN;
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            z_active_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            z_active_q   <= z_active_d;
            cnt_q        <= cnt_d;
        end
    end

    // Leaving RUN waits for the slot so a held span still issues in the old mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ZRS_RUN:    if (!mode_match && !slot_valid_q) state_d = ZRS_DRAIN;
            ZRS_DRAIN:  if (fifo_empty && cnt_q <= CNT_W'(1)) state_d = ZRS_SWITCH;
            ZRS_SWITCH: state_d = ZRS_RUN;
            default:    state_d = ZRS_RUN;
        endcase
    end

    always_comb begin
        in_ready  = state_q == ZRS_RUN && mode_match && credit_ok && (!slot_valid_q || slot_fire);
        busy      = !(state_q == ZRS_RUN && !slot_valid_q && fifo_empty);
        read_read = slot_valid_q && z_active_q;
        enqueue   = slot_fire;
    end

    // Spans with no live pixel are consumed without touching the slot.
    always_comb begin
        slot_valid_d = slot_fire ? 1'b0 : slot_valid_q;
        slot_d       = slot_q;
        if (accept && in_pixel_active != '0) begin
            slot_valid_d = 1'b1;
            slot_d       = {in_color_address, in_color, in_z_address, in_z, in_pixel_active};
        end
        cnt_d      = state_q == ZRS_DRAIN ? (fifo_empty ? cnt_q - CNT_W'(cnt_q != '0) : DRAIN_LOAD)
                                          : (state_d == ZRS_DRAIN ? DRAIN_LOAD : '0);
        z_active_d = state_q == ZRS_SWITCH ? z_request : z_active_q;
    end

    assign z_active      = z_active_q;
    assign read_address  = slot_q.z_address;
    assign color_address = slot_q.color_address;
    assign color         = slot_q.color;
    assign z_address     = slot_q.z_address;
    assign z             = slot_q.z;
    assign pixel_active  = slot_q.pixel_active;

endmodule

// File: tb/tb_z_read_scheduler.sv
// tb_z_read_scheduler: directed scenario tasks plus a randomized run checked
// against a span-queue reference of the scheduler's ordering and handshake rules.
module tb_z_read_scheduler;
    import z_read_scheduler_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              z_request = 1'b0;
    logic              z_active, busy, in_ready, read_read, enqueue;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] in_color_address = '0, in_z_address = '0;
    logic [PIX_W-1:0]  in_color = '0, in_z = '0;
    logic [MASK_W-1:0] in_pixel_active = '0;
    logic [ADDR_W-1:0] read_address, color_address, z_address;
    logic              read_waitrequest = 1'b0;
    logic [4:0]        fifo_size = '0;
    logic [PIX_W-1:0]  color, z;
    logic [MASK_W-1:0] pixel_active;

    int tests = 0;
    int fails = 0;

    z_read_scheduler dut (
        .clock(clock), .reset_n(reset_n), .z_request(z_request), .z_active(z_active), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_color_address(in_color_address), .in_color(in_color),
        .in_z_address(in_z_address), .in_z(in_z), .in_pixel_active(in_pixel_active),
        .read_address(read_address), .read_read(read_read), .read_waitrequest(read_waitrequest),
        .fifo_size(fifo_size), .enqueue(enqueue), .color_address(color_address), .color(color),
        .z_address(z_address), .z(z), .pixel_active(pixel_active)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

    function automatic span_t rand_span(input logic [1:0] mask);
        span_t s;
        s.color_address = ADDR_W'($urandom);
        s.color         = {$urandom, $urandom};
        s.z_address     = ADDR_W'($urandom);
        s.z             = {$urandom, $urandom};
        s.pixel_active  = mask;
        return s;
    endfunction

    function automatic span_t get_out();
        return {color_address, color, z_address, z, pixel_active};
    endfunction

    task automatic drive(input logic v, input span_t s);
        in_valid         = v;
        in_color_address = s.color_address;
        in_color         = s.color;
        in_z_address     = s.z_address;
        in_z             = s.z;
        in_pixel_active  = s.pixel_active;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        @(negedge clock);
        tests++; if (z_active !== 1'b0) begin fails++; $display("FAIL reset_z_active got %b exp 0", z_active); end
        tests++; if (read_read !== 1'b0) begin fails++; $display("FAIL reset_read_read got %b exp 0", read_read); end
        tests++; if (enqueue !== 1'b0) begin fails++; $display("FAIL reset_enqueue got %b exp 0", enqueue); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tick();
    endtask

    task automatic test_z_off_burst();
        span_t sp[8];
        foreach (sp[i]) sp[i] = rand_span(2'($urandom_range(1, 3)));
        for (int c = 0; c < 10; c++) begin
            drive(c < 8, sp[c % 8]);
            @(negedge clock);
            if (c < 8) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL burst_in_ready c=%0d got %b exp 1", c, in_ready); end
            end
            tests++; if (enqueue !== (c >= 1 && c <= 8)) begin fails++; $display("FAIL burst_enqueue c=%0d got %b exp %b", c, enqueue, c >= 1 && c <= 8); end
            tests++; if (read_read !== 1'b0) begin fails++; $display("FAIL burst_read_read c=%0d got %b exp 0", c, read_read); end
            if (c >= 1 && c <= 8) begin
                tests++; if (get_out() !== sp[c-1]) begin fails++; $display("FAIL burst_data c=%0d got %h exp %h", c, get_out(), sp[c-1]); end
            end
            tick();
        end
    endtask

    task automatic test_credit();
        span_t s = rand_span(2'b11);
        drive(1'b1, s);
        fifo_size = 5'd28;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL credit28_in_ready got %b exp 0", in_ready); end
            tests++; if (enqueue !== 1'b0) begin fails++; $display("FAIL credit28_enqueue got %b exp 0", enqueue); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL credit28_busy got %b exp 1", busy); end
            tick();
        end
        fifo_size = 5'd31;
        @(negedge clock);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL credit31_in_ready got %b exp 0", in_ready); end
        tick();
        fifo_size = 5'd27;
        @(negedge clock);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL credit27_in_ready got %b exp 1", in_ready); end
        tick();
        drive(1'b0, s);
        @(negedge clock);
        tests++; if (enqueue !== 1'b1) begin fails++; $display("FAIL credit27_enqueue got %b exp 1", enqueue); end
        tests++; if (get_out() !== s) begin fails++; $display("FAIL credit27_data got %h exp %h", get_out(), s); end
        tick();
        fifo_size = '0;
    endtask

    task automatic test_zero_mask();
        span_t a = rand_span(2'b00);
        span_t b = rand_span(2'b01);
        drive(1'b1, a);
        @(negedge clock);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zmask_accept got %b exp 1", in_ready); end
        tick();
        drive(1'b1, b);
        @(negedge clock);
        tests++; if (enqueue !== 1'b0) begin fails++; $display("FAIL zmask_enqueue got %b exp 0", enqueue); end
        tests++; if (read_read !== 1'b0) begin fails++; $display("FAIL zmask_read_read got %b exp 0", read_read); end
        tick();
        drive(1'b0, b);
        @(negedge clock);
        tests++; if (enqueue !== 1'b1) begin fails++; $display("FAIL zmask_next_enqueue got %b exp 1", enqueue); end
        tests++; if (get_out() !== b) begin fails++; $display("FAIL zmask_next_data got %h exp %h", get_out(), b); end
        tick();
    endtask

    task automatic test_mode_switch();
        span_t s = rand_span(2'b11);
        span_t t = rand_span(2'b10);
        int n = 0;
        bit seen = 0;
        logic zprev = 1'bx;
        fifo_size = 5'd3;
        drive(1'b1, s);
        @(negedge clock);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL msw_first_accept got %b exp 1", in_ready); end
        tick();
        drive(1'b0, s);
        z_request = 1'b1;
        read_waitrequest = 1'b1;
        @(negedge clock);
        tests++; if (enqueue !== 1'b1) begin fails++; $display("FAIL msw_old_mode_enqueue got %b exp 1", enqueue); end
        tests++; if (read_read !== 1'b0) begin fails++; $display("FAIL msw_old_mode_read got %b exp 0", read_read); end
        tests++; if (get_out() !== s) begin fails++; $display("FAIL msw_old_mode_data got %h exp %h", get_out(), s); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL msw_pending_in_ready got %b exp 0", in_ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            fifo_size = (c < 2 || c == 4) ? 5'd3 : 5'd0;
            if (c == 4) fifo_size = 5'd1;
            @(negedge clock);
            tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL msw_drain_hold c=%0d got in_ready=%b busy=%b exp 0 1", c, in_ready, busy); end
            tick();
        end
        fifo_size = '0;
        read_waitrequest = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (in_ready === 1'b1) seen = 1;
            else begin
                n++;
                zprev = z_active;
                tick();
            end
        end
        tests++; if (!seen || n != 5) begin fails++; $display("FAIL msw_latency got seen=%0d n=%0d exp 1 5", seen, n); end
        tests++; if (zprev !== 1'b0 || z_active !== 1'b1) begin fails++; $display("FAIL msw_z_active got prev=%b now=%b exp 0 1", zprev, z_active); end
        drive(1'b1, t);
        tick();
        drive(1'b0, t);
        @(negedge clock);
        tests++; if (read_read !== 1'b1 || enqueue !== 1'b1) begin fails++; $display("FAIL msw_resume got read=%b enq=%b exp 1 1", read_read, enqueue); end
        tests++; if (read_address !== t.z_address) begin fails++; $display("FAIL msw_resume_addr got %h exp %h", read_address, t.z_address); end
        tick();
    endtask

    task automatic test_waitrequest();
        span_t a = rand_span(2'b11);
        a.z_address = 29'h100;
        fifo_size = '0;
        read_waitrequest = 1'b1;
        drive(1'b1, a);
        tick();
        drive(1'b0, a);
        for (int c = 1; c <= 5; c++) begin
            read_waitrequest = c <= 3;
            @(negedge clock);
            tests++; if (read_read !== (c <= 4)) begin fails++; $display("FAIL wait_read_read c=%0d got %b exp %b", c, read_read, c <= 4); end
            tests++; if (enqueue !== (c == 4)) begin fails++; $display("FAIL wait_enqueue c=%0d got %b exp %b", c, enqueue, c == 4); end
            if (c <= 4) begin
                tests++; if (read_address !== 29'h100 || get_out() !== a) begin fails++; $display("FAIL wait_stable c=%0d got %h exp %h", c, get_out(), a); end
            end
            if (c <= 3) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL wait_in_ready c=%0d got %b exp 0", c, in_ready); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        span_t a = rand_span(2'b11);
        a.z_address[0] = 1'b1;
        fifo_size = '0;
        read_waitrequest = 1'b1;
        drive(1'b1, a);
        tick();
        drive(1'b0, a);
        @(negedge clock);
        tests++; if (read_read !== 1'b1) begin fails++; $display("FAIL rmid_held got %b exp 1", read_read); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (read_read !== 1'b0 || enqueue !== 1'b0) begin fails++; $display("FAIL rmid_cmd got read=%b enq=%b exp 0 0", read_read, enqueue); end
        tests++; if (z_active !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_state got z_active=%b busy=%b exp 0 0", z_active, busy); end
        tests++; if (get_out() !== '0) begin fails++; $display("FAIL rmid_data got %h exp 0", get_out()); end
        z_request = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++; if (enqueue !== 1'b0 || read_read !== 1'b0) begin fails++; $display("FAIL rmid_after c=%0d got read=%b enq=%b exp 0 0", c, read_read, enqueue); end
            tick();
        end
        read_waitrequest = 1'b0;
    endtask

    task automatic test_random();
        span_t q[$];
        span_t cur, want;
        int enq_count = 0;
        logic exp_enq;
        for (int c = 0; c < 1200; c++) begin
            if (c < 1000) begin
                if ($urandom_range(0, 39) == 0) z_request = ~z_request;
                fifo_size = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(0, 31));
                read_waitrequest = $urandom_range(0, 2) == 0;
                cur = rand_span(2'($urandom_range(0, 3)));
                drive($urandom_range(0, 2) != 0, cur);
            end else begin
                fifo_size = '0;
                read_waitrequest = 1'b0;
                drive(1'b0, cur);
            end
            @(negedge clock);
            exp_enq = q.size() != 0 && (!z_active || !read_waitrequest);
            tests++; if (enqueue !== exp_enq) begin fails++; $display("FAIL rand_enqueue c=%0d got %b exp %b", c, enqueue, exp_enq); end
            tests++; if (read_read !== (z_active && q.size() != 0)) begin fails++; $display("FAIL rand_read_read c=%0d got %b exp %b", c, read_read, z_active && q.size() != 0); end
            if (in_ready === 1'b1) begin
                tests++; if (fifo_size >= 5'd28 || z_request !== z_active) begin fails++; $display("FAIL rand_in_ready c=%0d got 1 exp 0 (fifo=%0d req=%b act=%b)", c, fifo_size, z_request, z_active); end
            end
            if (busy === 1'b0) begin
                tests++; if (q.size() != 0 || fifo_size != 0) begin fails++; $display("FAIL rand_busy c=%0d got 0 exp 1", c); end
                if (z_request === z_active) begin
                    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rand_idle_ready c=%0d got %b exp 1", c, in_ready); end
                end
            end
            if (enqueue === 1'b1 && q.size() != 0) begin
                want = q.pop_front();
                enq_count++;
                tests++; if (get_out() !== want) begin fails++; $display("FAIL rand_data c=%0d got %h exp %h", c, get_out(), want); end
            end
            if (in_valid && in_ready === 1'b1 && cur.pixel_active != 2'b00) q.push_back(cur);
            tick();
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_leftover got %0d exp 0", q.size()); end
        tests++; if (enq_count < 50) begin fails++; $display("FAIL rand_progress got %0d enqueues exp >=50", enq_count); end
    endtask

    initial begin
        test_reset();
        test_z_off_burst();
        test_credit();
        test_zero_mask();
        test_mode_switch();
        test_waitrequest();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/z_read_scheduler.md
# z_read_scheduler

Front-end controller for the Z-test read FIFO. It accepts two-pixel spans from the rasterizer and issues one 64-bit Z read per span on the Avalon read master. In the same cycle the read is accepted, it enqueues the span into the read FIFO. It throttles on FIFO occupancy and sequences a safe drain-and-switch whenever the Z-test mode changes. The block sits between the span generator and the read FIFO and owns the `z_active` signal that both blocks share.

## Interface
- `FIFO_DEPTH`, 32, depth of the downstream read FIFO.
- `FIFO_DEPTH_LOG2`, 5, width of `fifo_size`.
- `SLACK`, 4, headroom kept free in the FIFO; must be ≥3.
- `DRAIN_CYCLES`, 4, consecutive empty cycles required before a mode switch (covers the 2-cycle compare pipeline plus margin).

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `z_request` in 1: desired Z-test mode (level).
- `z_active` out 1: current committed mode, fanned to the read FIFO.
- `busy` out 1: high unless in RUN with the slot empty and `fifo_size`==0.
- `in_valid` in 1, `in_ready` out 1: upstream span handshake.
- `in_color_address` in 29, `in_color` in 64, `in_z_address` in 29, `in_z` in 64, `in_pixel_active` in 2 (bit 0 = left pixel).
- `read_address` out 29, `read_read` out 1, `read_waitrequest` in 1: Avalon read command; data returns directly to the FIFO.
- `fifo_size` in FIFO_DEPTH_LOG2: FIFO `usedw`.
- `enqueue` out 1: FIFO write strobe.
- `color_address` out 29, `color` out 64, `z_address` out 29, `z` out 64, `pixel_active` out 2: FIFO write data.

## Operation
- One-entry holding slot with registered fields and a `slot_valid` flag. All enqueue and read data comes from the slot.
- `slot_fire` = `slot_valid` && (!`z_active` || !`read_waitrequest`).
- `read_read` = `slot_valid` && `z_active`.
- `read_address` = slot Z address.
- `enqueue` = `slot_fire`. These are combinational from slot state and waitrequest, per Avalon.
- `credit_ok` = `fifo_size` < FIFO_DEPTH−SLACK. The FIFO therefore never reaches full, so `usedw` never wraps to 0 at full.
- `in_ready` = state==RUN && `z_request`==`z_active` && `credit_ok` && (!`slot_valid` || `slot_fire`).
- Accept (`in_valid` && `in_ready`) loads the slot.
- If an accepted span has `in_pixel_active`==2'b00, it is consumed and discarded: the slot is not loaded and there is no read and no enqueue.
- FSM:
  - RUN: normal flow. When `z_request`≠`z_active`, stop accepting and wait for the slot to empty, then go to DRAIN.
  - DRAIN: load a counter with DRAIN_CYCLES. The counter decrements while `fifo_size`==0 and reloads when it is nonzero. At 0, go to SWITCH.
  - SWITCH: one cycle. `z_active` <= `z_request` (value sampled this cycle), then return to RUN.
- If `z_request` toggles back during DRAIN, the sequence still completes. SWITCH then loads the now-equal value, which is a no-op.
- Because each FIFO entry owns exactly one outstanding read, `fifo_size`==0 in Z mode implies no reads are in flight.

## Timing
- Reset values: `z_active`=0, FSM=RUN, `slot_valid`=0, drain counter=0. Hence `read_read`=0, `enqueue`=0, `busy`=0, and `in_ready`=1 once `z_request`=0.
- Accept in cycle N gives `read_read`/`enqueue` in N+1. With waitrequest low the throughput is one span per cycle.
- Waitrequest held high: `read_read`, `read_address` and all slot data stay stable, with no enqueue.
- A slot being held does not block a mode change that is already pending. The slot still fires in the old mode before DRAIN.
- Reset asserted mid-operation: the slot is dropped and any in-flight reads are abandoned. The FIFO shares the same reset and clears via `aclr`.
- Mode-switch latency from slot empty with the FIFO already empty: DRAIN_CYCLES+2 cycles until `in_ready` can rise.

## Structure
- Shared package holds the span field widths (29-bit address, 64-bit pixel pair, 2-bit mask) and the FSM state encoding `ZRS_RUN`/`ZRS_DRAIN`/`ZRS_SWITCH`.
- No sub-module is required. The slot and FSM live in one module. At the top level it is instantiated next to the read FIFO, sharing `FIFO_DEPTH`.

## Test plan
- Z off, 8 back-to-back spans, waitrequest=0:
  - 8 enqueues on consecutive cycles.
  - `read_read` never asserted.
  - Data matches the inputs.
- Z on, waitrequest high for 3 cycles on span A (`z_address` 0x100):
  - `read_read` is high for 4 cycles with address 0x100 stable.
  - Exactly one enqueue, in the 4th cycle.
- `fifo_size` driven to 28 (FIFO_DEPTH 32, SLACK 4):
  - `in_ready`=0 and no new accepts.
  - Dropping to 27 re-enables `in_ready` the same cycle.
- Span with `pixel_active`=00:
  - Accepted.
  - No `read_read`, no `enqueue`.
  - The next span still issues in the following cycle.
- `z_request` 0→1 while the slot is full and `fifo_size`=3:
  - The slot fires in Z-off mode.
  - `in_ready`=0 until `fifo_size` has been 0 for 4 cycles.
  - `z_active` rises one cycle later, then accepts resume.
- Reset pulse while waitrequest is held high:
  - All outputs return to their reset values asynchronously.
  - No enqueue after release.
